dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-ported `DataMemory` between the core's load/store path (port 0) and the program-loader/debug port (port 1). Grants at most one access per cycle using round-robin (or fixed) priority, with an optional bounded lock for back-to-back bursts. It also rejects misaligned and out-of-range accesses, and returns read data and error status to the winning requester one cycle later.

## Interface
- `DATA_W`, 32, data width of both ports and memory.
- `ADDR_W`, 32, byte-address width.
- `MEM_BYTES`, 1024, memory size in bytes; a legal address is `< MEM_BYTES`.
- `FIXED_PRIO`, 0, 1 = port 0 always wins contention; 0 = round-robin.
- `MAX_LOCK`, 8, maximum consecutive locked grants before a forced handoff.
- `clk`  in  1  sole clock; everything is updated on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  access request.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `lock0` / `lock1`  in  1  requests grant retention on the next cycle.
- `addr0` / `addr1`  in  ADDR_W  byte address.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `gnt0` / `gnt1`  out  1  request accepted this cycle.
- `rvalid0` / `rvalid1`  out  1  response valid; one cycle after the grant.
- `rdata0` / `rdata1`  out  DATA_W  read data.
- `err0` / `err1`  out  1  error flag, qualified by `rvalid`.
- `mem_read`, `mem_write`  out  1  memory enables.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid the cycle after `mem_read`.

## Operation
- **Handshake.** A requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`. The transfer completes in the cycle where `req && gnt` is true.
- **Arbitration state:**
  - `last`: 1 bit, the port granted most recently.
  - `lock_own`: 1 bit valid plus a port id.
  - `lock_cnt`: counter of width clog2(MAX_LOCK)+1.
- **Winner selection:**
  - If only one port requests, that port wins.
  - If both request and `lock_own` is valid, the owner wins, unless `lock_cnt == MAX_LOCK`. In that case the other port wins and the lock is cleared.
  - Otherwise, if `FIXED_PRIO=1`, port 0 wins.
  - Otherwise the port that is not `last` wins.
- **Lock update:**
  - Set `last` to the winner on every grant.
  - If the winner asserts `lock` and the lock is not being forced off, set `lock_own` to the winner and increment `lock_cnt`. On a new owner, `lock_cnt` restarts at 1.
  - Clear the lock on: the owner granted with `lock` low, the owner not requesting, or a forced handoff.
- **Access checks:**
  - A granted access is legal when `addr[1:0]==0` and `addr < MEM_BYTES`.
  - Legal accesses drive `mem_read = !we` or `mem_write = we`, plus `mem_addr` and `mem_wdata` from the winner.
  - Illegal accesses are still granted but drive no memory enable.
- **Responses:**
  - Legal read: next cycle `rvalid=1`, `err=0`, `rdata=mem_rdata`.
  - Legal write: no response.
  - Illegal read or write: next cycle `rvalid=1`, `err=1`, `rdata=0`.
- With no grant, memory enables are 0 and `mem_addr`/`mem_wdata` are 0.

## Timing
- `gnt*` and all `mem_*` outputs are combinational from the request inputs and arbitration state, with zero latency. While `reset` is high they are forced to 0.
- `rvalid*`, `rdata*` and `err*` are registered: a grant in cycle N produces the response in cycle N+1.
- Throughput is one access per cycle. Back-to-back grants to the same or alternating ports are allowed.
- Values on reset:
  - `last=1`, so port 0 wins the first contention.
  - Lock cleared, `lock_cnt=0`.
  - All `rvalid`, `err` and `rdata` are 0.
- Reset asserted while a read is in flight: the pending response is dropped, and no `rvalid` appears after reset.
- The same cycle a response is issued for an earlier grant, a new grant may occur.
- `lock` on a non-granted port is ignored.
- A write and the response to an earlier read on the other port may coincide. Each is independent.

## Test plan
- **Contention after reset:** `req0=req1=1` reads to 0x10 and 0x20 held for 2 cycles -> cycle 0: `gnt0`, `mem_addr=0x10`; cycle 1: `gnt1`, `mem_addr=0x20`, `rvalid0` carrying `mem[0x10]`; cycle 2: `rvalid1`.
- **Lock with forced handoff:** port 1 requests continuously with `lock1=1`, `MAX_LOCK=8`, port 0 also requesting -> port 1 gets exactly 8 consecutive grants, then `gnt0`, then arbitration resumes round-robin.
- **Illegal accesses:** write to 0x102 (misaligned), then read at 0x400 (`MEM_BYTES=1024`) -> `gnt` asserted, `mem_write=mem_read=0`, next cycle `rvalid=1`, `err=1`, `rdata=0` for each.
- **Fixed priority:** `FIXED_PRIO=1`, both requesting for 4 cycles -> `gnt0` every cycle, `gnt1` never.
- **Write-then-read:** write 0xDEADBEEF to 0x40 via port 1, then read 0x40 via port 0 -> `rdata0=0xDEADBEEF`, `err0=0`; no `rvalid1` for the write.
- **Reset mid-read:** `reset` asserted the cycle after a read grant -> no `rvalid` and all outputs 0 the cycle after; after deassert, the first contention is granted to port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-ported data memory between the core load/store path
// (port 0) and the program-loader/debug path (port 1). At most one access is
// granted per cycle. Contention is settled by round-robin, or by fixed
// priority to port 0 when FIXED_PRIO is set. A granted port can hold the
// memory for up to MAX_LOCK consecutive grants by asserting lock.
// Misaligned or out-of-range accesses are granted but never reach the memory.
// Instead they return an error response.
//
// Ports
//   clk, reset                  clock and synchronous active-high reset
//   req*/we*/lock*/addr*/wdata* per-port request, held until gnt*
//   gnt*                        combinational grant for this cycle
//   rvalid*/rdata*/err*         response, one cycle after the grant
//   mem_read/mem_write          memory enables (legal accesses only)
//   mem_addr/mem_wdata          memory address / write data (0 when idle)
//   mem_rdata                   memory read data, valid the cycle after read
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_BYTES  = 1024,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_LOCK   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W      = $clog2(MAX_LOCK) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_LOCK);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_BYTES);

    // Arbitration state
    logic             last_r;
    logic             lock_vld_r;
    logic             lock_own_r;
    logic [CNT_W-1:0] lock_cnt_r;

    // Response state
    logic rvalid0_r, err0_r, rd_pend0_r;
    logic rvalid1_r, err1_r, rd_pend1_r;

    // Combinational decision signals
    logic              win_vld_s;
    logic              win_id_s;
    logic              forced_s;
    logic              sel_we_s;
    logic              sel_lock_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              legal_s;
    logic              access_s;
    logic              last_n_s;
    logic              lock_vld_n_s;
    logic              lock_own_n_s;
    logic [CNT_W-1:0]  lock_cnt_n_s;

    // Winner selection: sole requester, then lock owner (until the lock
    // budget is exhausted), then fixed priority or round-robin.
    always_comb begin
        win_vld_s = 1'b0;
        win_id_s  = 1'b0;
        forced_s  = 1'b0;
        if (reset) begin
            win_vld_s = 1'b0;
        end else if (req0 && req1) begin
            win_vld_s = 1'b1;
            if (lock_vld_r) begin
                if (lock_cnt_r == CNT_MAX) begin
                    forced_s = 1'b1;
                    win_id_s = ~lock_own_r;
                end else begin
                    win_id_s = lock_own_r;
                end
            end else if (FIXED_PRIO != 0) begin
                win_id_s = 1'b0;
            end else begin
                win_id_s = ~last_r;
            end
        end else if (req0) begin
            win_vld_s = 1'b1;
            win_id_s  = 1'b0;
        end else if (req1) begin
            win_vld_s = 1'b1;
            win_id_s  = 1'b1;
        end else begin
            win_vld_s = 1'b0;
        end
    end

    // Winner's request fields and legality check
    always_comb begin
        sel_we_s    = win_id_s ? we1    : we0;
        sel_lock_s  = win_id_s ? lock1  : lock0;
        sel_addr_s  = win_id_s ? addr1  : addr0;
        sel_wdata_s = win_id_s ? wdata1 : wdata0;
        legal_s     = (sel_addr_s[1:0] == 2'b00) && (sel_addr_s < ADDR_LIMIT);
        access_s    = win_vld_s && legal_s;
    end

    // Grants and memory-side drive; illegal or absent accesses leave it idle
    always_comb begin
        gnt0      = win_vld_s && !win_id_s;
        gnt1      = win_vld_s &&  win_id_s;
        mem_read  = access_s && !sel_we_s;
        mem_write = access_s &&  sel_we_s;
        if (access_s) begin
            mem_addr  = sel_addr_s;
            mem_wdata = sel_wdata_s;
        end else begin
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
        end
    end

    // Next lock / round-robin state. The lock count saturates at MAX_LOCK
    // so that an uncontested owner is handed off at the next contention.
    always_comb begin
        last_n_s     = last_r;
        lock_vld_n_s = 1'b0;
        lock_own_n_s = 1'b0;
        lock_cnt_n_s = {CNT_W{1'b0}};
        if (win_vld_s) begin
            last_n_s = win_id_s;
            if (sel_lock_s && !forced_s) begin
                lock_vld_n_s = 1'b1;
                lock_own_n_s = win_id_s;
                if (lock_vld_r && (lock_own_r == win_id_s)) begin
                    if (lock_cnt_r == CNT_MAX) begin
                        lock_cnt_n_s = lock_cnt_r;
                    end else begin
                        lock_cnt_n_s = lock_cnt_r + CNT_W'(1);
                    end
                end else begin
                    lock_cnt_n_s = CNT_W'(1);
                end
            end else begin
                lock_vld_n_s = 1'b0;
            end
        end else begin
            last_n_s = last_r;
        end
    end

    // Arbitration and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r     <= 1'b1;
            lock_vld_r <= 1'b0;
            lock_own_r <= 1'b0;
            lock_cnt_r <= {CNT_W{1'b0}};
            rvalid0_r  <= 1'b0;
            err0_r     <= 1'b0;
            rd_pend0_r <= 1'b0;
            rvalid1_r  <= 1'b0;
            err1_r     <= 1'b0;
            rd_pend1_r <= 1'b0;
        end else begin
            last_r     <= last_n_s;
            lock_vld_r <= lock_vld_n_s;
            lock_own_r <= lock_own_n_s;
            lock_cnt_r <= lock_cnt_n_s;
            // Legal writes are silent; reads and every illegal access respond
            rvalid0_r  <= gnt0 && (!legal_s || !sel_we_s);
            err0_r     <= gnt0 && !legal_s;
            rd_pend0_r <= gnt0 && legal_s && !sel_we_s;
            rvalid1_r  <= gnt1 && (!legal_s || !sel_we_s);
            err1_r     <= gnt1 && !legal_s;
            rd_pend1_r <= gnt1 && legal_s && !sel_we_s;
        end
    end

    // Response outputs. Memory data arrives the cycle after the read, so the
    // read path steers it straight through. Reset masks a response that
    // would otherwise surface during the reset cycle itself.
    always_comb begin
        rvalid0 = rvalid0_r && !reset;
        err0    = err0_r    && !reset;
        rvalid1 = rvalid1_r && !reset;
        err1    = err1_r    && !reset;
        if (rd_pend0_r && !reset) begin
            rdata0 = mem_rdata;
        end else begin
            rdata0 = {DATA_W{1'b0}};
        end
        if (rd_pend1_r && !reset) begin
            rdata1 = mem_rdata;
        end else begin
            rdata1 = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run scored against a behavioural model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int MAX_LOCK = 8;
    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic        lock0 = 1'b0, lock1 = 1'b0;
    logic [31:0] addr0 = 32'd0, addr1 = 32'd0, wdata0 = 32'd0, wdata1 = 32'd0;

    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    logic        fgnt0, fgnt1, frvalid0, frvalid1, ferr0, ferr1, fmem_read, fmem_write;
    logic [31:0] frdata0, frdata1, fmem_addr, fmem_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_BYTES(MEM_BYTES), .FIXED_PRIO(0), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_BYTES(MEM_BYTES), .FIXED_PRIO(1), .MAX_LOCK(MAX_LOCK)) dut_fixed (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt0(fgnt0), .gnt1(fgnt1),
        .rvalid0(frvalid0), .rvalid1(frvalid1), .rdata0(frdata0), .rdata1(frdata1),
        .err0(ferr0), .err1(ferr1), .mem_read(fmem_read), .mem_write(fmem_write),
        .mem_addr(fmem_addr), .mem_wdata(fmem_wdata), .mem_rdata(mem_rdata));

    function automatic logic [31:0] init_word(int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Environment: synchronous single-port memory, reloaded on reset
    logic [31:0] mem_arr [0:255];
    logic [31:0] mem_rdata_r;
    assign mem_rdata = mem_rdata_r;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
            mem_rdata_r <= 32'd0;
        end else begin
            if (mem_write) mem_arr[mem_addr[9:2]] <= mem_wdata;
            if (mem_read)  mem_rdata_r <= mem_arr[mem_addr[9:2]];
        end
    end

    // ---------------- behavioural reference model ----------------
    // Index 0 models the round-robin instance, index 1 the fixed-priority one.
    int          m_w [2];
    bit          m_forced [2];
    int          m_last [2] = '{1, 1};
    int          m_owner [2] = '{-1, -1};
    int          m_cnt [2] = '{0, 0};
    logic [31:0] m_a, m_wd;
    logic        m_we, m_legal;
    logic        e_gnt0, e_gnt1, e_fg0, e_fg1, e_mr, e_mw;
    logic [31:0] e_maddr, e_mwd;
    logic        p_rv [2] = '{1'b0, 1'b0};
    logic        p_err [2] = '{1'b0, 1'b0};
    logic [31:0] p_rd [2] = '{32'd0, 32'd0};
    logic [31:0] exp_mem [0:255];

    task automatic model_eval();
        bit acc;
        for (int k = 0; k < 2; k++) begin
            m_forced[k] = 1'b0;
            if (reset || (!req0 && !req1)) m_w[k] = -1;
            else if (!req1) m_w[k] = 0;
            else if (!req0) m_w[k] = 1;
            else if (m_owner[k] >= 0) begin
                if (m_cnt[k] == MAX_LOCK) begin
                    m_forced[k] = 1'b1;
                    m_w[k] = 1 - m_owner[k];
                end else m_w[k] = m_owner[k];
            end
            else if (k == 1) m_w[k] = 0;
            else m_w[k] = 1 - m_last[k];
        end
        m_a  = (m_w[0] == 1) ? addr1 : addr0;
        m_wd = (m_w[0] == 1) ? wdata1 : wdata0;
        m_we = (m_w[0] == 1) ? we1 : we0;
        m_legal = (m_a % 32'd4 == 32'd0) && (m_a < 32'(MEM_BYTES));
        acc = (m_w[0] >= 0) && m_legal;
        e_gnt0 = (m_w[0] == 0);
        e_gnt1 = (m_w[0] == 1);
        e_fg0  = (m_w[1] == 0);
        e_fg1  = (m_w[1] == 1);
        e_mr   = acc && !m_we;
        e_mw   = acc && m_we;
        e_maddr = acc ? m_a : 32'd0;
        e_mwd   = acc ? m_wd : 32'd0;
    endtask

    task automatic model_commit();
        bit lk;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_last[k] = 1; m_owner[k] = -1; m_cnt[k] = 0;
                p_rv[k] = 1'b0; p_err[k] = 1'b0; p_rd[k] = 32'd0;
            end
            for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
        end else begin
            for (int k = 0; k < 2; k++) begin
                p_rv[k] = 1'b0; p_err[k] = 1'b0; p_rd[k] = 32'd0;
            end
            if (m_w[0] >= 0) begin
                if (!m_legal) begin
                    p_rv[m_w[0]] = 1'b1; p_err[m_w[0]] = 1'b1;
                end else if (!m_we) begin
                    p_rv[m_w[0]] = 1'b1; p_rd[m_w[0]] = exp_mem[m_a / 32'd4];
                end else begin
                    exp_mem[m_a / 32'd4] = m_wd;
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (m_w[k] < 0) begin
                    m_owner[k] = -1; m_cnt[k] = 0;
                end else begin
                    m_last[k] = m_w[k];
                    lk = (m_w[k] == 0) ? lock0 : lock1;
                    if (lk && !m_forced[k]) begin
                        if (m_owner[k] == m_w[k]) begin
                            if (m_cnt[k] < MAX_LOCK) m_cnt[k]++;
                        end else begin
                            m_owner[k] = m_w[k]; m_cnt[k] = 1;
                        end
                    end else begin
                        m_owner[k] = -1; m_cnt[k] = 0;
                    end
                end
            end
        end
    endtask

    // Outputs are sampled on the falling edge; inputs change 1 after the rising edge
    task automatic cycle_begin();
        @(negedge clk);
        model_eval();
    endtask

    task automatic cycle_end();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int s = $urandom_range(0, 9);
        if (s == 0) return 32'($urandom_range(0, 255)) * 32'd4 + 32'($urandom_range(1, 3));
        else if (s == 1) return 32'd1024 + 32'($urandom_range(0, 255)) * 32'd4;
        else return 32'($urandom_range(0, 15)) * 32'd4;
    endfunction

    task automatic new_req(int p);
        logic r, w, l;
        logic [31:0] a, d;
        r = ($urandom_range(0, 3) != 0);
        w = 1'($urandom_range(0, 1));
        l = ($urandom_range(0, 2) == 0);
        a = rand_addr();
        d = $urandom;
        if (p == 0) begin req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d; end
        else        begin req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d; end
    endtask

    task automatic idle();
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cycle_begin();
            n_cmp++;
            if ({gnt0, gnt1, fgnt0, fgnt1, mem_read, mem_write, rvalid0, rvalid1, err0, err1} !== 10'd0) begin
                n_bad++; $display("FAIL reset_ctl: got %b expected 0", {gnt0, gnt1, fgnt0, fgnt1, mem_read, mem_write, rvalid0, rvalid1, err0, err1});
            end
            n_cmp++;
            if ({mem_addr, mem_wdata, rdata0, rdata1} !== 128'd0) begin
                n_bad++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, rdata0, rdata1});
            end
            cycle_end();
        end
        reset = 1'b0; idle();
        cycle_begin();
        n_cmp++;
        if ({rvalid0, rvalid1, gnt0, gnt1} !== 4'd0) begin
            n_bad++; $display("FAIL reset_idle: got %b expected 0000", {rvalid0, rvalid1, gnt0, gnt1});
        end
        cycle_end();
    endtask

    task automatic test_contention();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'h10; addr1 = 32'h20;
        cycle_begin();
        n_cmp++;
        if ({gnt0, gnt1, mem_read, mem_addr} !== {3'b101, 32'h10}) begin
            n_bad++; $display("FAIL cont_c0: got g=%b%b rd=%b a=%h expected g=10 rd=1 a=10", gnt0, gnt1, mem_read, mem_addr);
        end
        cycle_end();
        cycle_begin();
        n_cmp++;
        if ({gnt0, gnt1, mem_read, mem_addr} !== {3'b011, 32'h20}) begin
            n_bad++; $display("FAIL cont_c1: got g=%b%b rd=%b a=%h expected g=01 rd=1 a=20", gnt0, gnt1, mem_read, mem_addr);
        end
        n_cmp++;
        if ({rvalid0, err0, rdata0} !== {2'b10, init_word(4)}) begin
            n_bad++; $display("FAIL cont_rsp0: got v=%b e=%b d=%h expected v=1 e=0 d=%h", rvalid0, err0, rdata0, init_word(4));
        end
        cycle_end();
        idle();
        cycle_begin();
        n_cmp++;
        if ({rvalid1, err1, rdata1, rvalid0} !== {2'b10, init_word(8), 1'b0}) begin
            n_bad++; $display("FAIL cont_rsp1: got v=%b e=%b d=%h v0=%b expected v=1 e=0 d=%h v0=0", rvalid1, err1, rdata1, rvalid0, init_word(8));
        end
        cycle_end();
    endtask

    task automatic test_lock_handoff();
        int run = 0;
        req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 32'h30;
        for (int c = 0; c < 8; c++) begin
            cycle_begin();
            if (gnt1 && !gnt0) run++;
            cycle_end();
            req0 = 1'b1; we0 = 1'b0; addr0 = 32'h34; lock0 = 1'b0;
        end
        n_cmp++;
        if (run != 8) begin
            n_bad++; $display("FAIL lock_run: got %0d locked grants expected 8", run);
        end
        cycle_begin();
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b10) begin
            n_bad++; $display("FAIL lock_handoff: got g=%b%b expected g=10", gnt0, gnt1);
        end
        cycle_end();
        lock1 = 1'b0;
        cycle_begin();
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b01) begin
            n_bad++; $display("FAIL lock_rr1: got g=%b%b expected g=01", gnt0, gnt1);
        end
        cycle_end();
        cycle_begin();
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b10) begin
            n_bad++; $display("FAIL lock_rr2: got g=%b%b expected g=10", gnt0, gnt1);
        end
        cycle_end();
    endtask

    task automatic test_illegal();
        idle();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h102; wdata1 = 32'h1234_5678;
        cycle_begin();
        n_cmp++;
        if ({gnt0, gnt1, mem_read, mem_write, mem_addr} !== {4'b0100, 32'h0}) begin
            n_bad++; $display("FAIL ill_wr: got g=%b%b rd=%b wr=%b a=%h expected g=01 rd=0 wr=0 a=0", gnt0, gnt1, mem_read, mem_write, mem_addr);
        end
        cycle_end();
        req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h400;
        cycle_begin();
        n_cmp++;
        if ({gnt0, gnt1, mem_read, mem_write} !== 4'b1000) begin
            n_bad++; $display("FAIL ill_rd: got g=%b%b rd=%b wr=%b expected g=10 rd=0 wr=0", gnt0, gnt1, mem_read, mem_write);
        end
        n_cmp++;
        if ({rvalid1, err1, rdata1} !== {2'b11, 32'h0}) begin
            n_bad++; $display("FAIL ill_rsp1: got v=%b e=%b d=%h expected v=1 e=1 d=0", rvalid1, err1, rdata1);
        end
        cycle_end();
        idle();
        cycle_begin();
        n_cmp++;
        if ({rvalid0, err0, rdata0, rvalid1} !== {2'b11, 32'h0, 1'b0}) begin
            n_bad++; $display("FAIL ill_rsp0: got v=%b e=%b d=%h v1=%b expected v=1 e=1 d=0 v1=0", rvalid0, err0, rdata0, rvalid1);
        end
        cycle_end();
    endtask

    task automatic test_fixed_prio();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'h0; addr1 = 32'h4;
        for (int c = 0; c < 4; c++) begin
            cycle_begin();
            n_cmp++;
            if ({fgnt0, fgnt1} !== 2'b10) begin
                n_bad++; $display("FAIL fixed_c%0d: got g=%b%b expected g=10", c, fgnt0, fgnt1);
            end
            cycle_end();
        end
        idle();
    endtask

    task automatic test_write_read();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'hDEAD_BEEF;
        cycle_begin();
        n_cmp++;
        if ({gnt1, mem_write, mem_addr, mem_wdata} !== {2'b11, 32'h40, 32'hDEAD_BEEF}) begin
            n_bad++; $display("FAIL wr_drive: got g1=%b wr=%b a=%h d=%h expected g1=1 wr=1 a=40 d=deadbeef", gnt1, mem_write, mem_addr, mem_wdata);
        end
        cycle_end();
        req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
        cycle_begin();
        n_cmp++;
        if ({rvalid1, gnt0, mem_read} !== 3'b011) begin
            n_bad++; $display("FAIL wr_norsp: got v1=%b g0=%b rd=%b expected v1=0 g0=1 rd=1", rvalid1, gnt0, mem_read);
        end
        cycle_end();
        idle();
        cycle_begin();
        n_cmp++;
        if ({rvalid0, err0, rdata0} !== {2'b10, 32'hDEAD_BEEF}) begin
            n_bad++; $display("FAIL rd_back: got v=%b e=%b d=%h expected v=1 e=0 d=deadbeef", rvalid0, err0, rdata0);
        end
        cycle_end();
    endtask

    task automatic test_reset_mid_read();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        cycle_begin();
        n_cmp++;
        if (gnt0 !== 1'b1) begin
            n_bad++; $display("FAIL rmr_gnt: got %b expected 1", gnt0);
        end
        cycle_end();
        reset = 1'b1; idle();
        cycle_begin();
        n_cmp++;
        if ({gnt0, gnt1, mem_read, mem_write, rvalid0, rvalid1, err0, err1, rdata0, mem_addr} !== 72'd0) begin
            n_bad++; $display("FAIL rmr_during: got v0=%b d0=%h g=%b%b expected all 0", rvalid0, rdata0, gnt0, gnt1);
        end
        cycle_end();
        reset = 1'b0;
        cycle_begin();
        n_cmp++;
        if ({rvalid0, rvalid1, rdata0} !== 34'd0) begin
            n_bad++; $display("FAIL rmr_after: got v0=%b v1=%b d0=%h expected 0", rvalid0, rvalid1, rdata0);
        end
        cycle_end();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'h10; addr1 = 32'h20;
        cycle_begin();
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b10) begin
            n_bad++; $display("FAIL rmr_first: got g=%b%b expected g=10", gnt0, gnt1);
        end
        cycle_end();
        idle();
        cycle_begin();
        cycle_end();
    endtask

    task automatic test_random();
        logic g0, g1;
        new_req(0); new_req(1);
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            cycle_begin();
            n_cmp++;
            if ({gnt0, gnt1, mem_read, mem_write, fgnt0, fgnt1} !== {e_gnt0, e_gnt1, e_mr, e_mw, e_fg0, e_fg1}) begin
                n_bad++; $display("FAIL rand_ctl c%0d: got %b expected %b", c, {gnt0, gnt1, mem_read, mem_write, fgnt0, fgnt1}, {e_gnt0, e_gnt1, e_mr, e_mw, e_fg0, e_fg1});
            end
            n_cmp++;
            if ({mem_addr, mem_wdata} !== {e_maddr, e_mwd}) begin
                n_bad++; $display("FAIL rand_mem c%0d: got a=%h d=%h expected a=%h d=%h", c, mem_addr, mem_wdata, e_maddr, e_mwd);
            end
            n_cmp++;
            if ({rvalid0, err0, rdata0} !== {p_rv[0] && !reset, p_err[0] && !reset, reset ? 32'd0 : p_rd[0]}) begin
                n_bad++; $display("FAIL rand_rsp0 c%0d: got v=%b e=%b d=%h expected v=%b e=%b d=%h", c, rvalid0, err0, rdata0, p_rv[0] && !reset, p_err[0] && !reset, reset ? 32'd0 : p_rd[0]);
            end
            n_cmp++;
            if ({rvalid1, err1, rdata1} !== {p_rv[1] && !reset, p_err[1] && !reset, reset ? 32'd0 : p_rd[1]}) begin
                n_bad++; $display("FAIL rand_rsp1 c%0d: got v=%b e=%b d=%h expected v=%b e=%b d=%h", c, rvalid1, err1, rdata1, p_rv[1] && !reset, p_err[1] && !reset, reset ? 32'd0 : p_rd[1]);
            end
            g0 = e_gnt0; g1 = e_gnt1;
            cycle_end();
            if (!req0 || g0) new_req(0);
            if (!req1 || g1) new_req(1);
        end
        reset = 1'b0; idle();
        cycle_begin();
        cycle_end();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_lock_handoff();
        test_illegal();
        test_fixed_prio();
        test_write_read();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
